// File: rtl/video_timing_gen.sv
// Raster timing generator with a fixed-latency sync/DE alignment stage in front of hdmi.
// Optional colour-bar source is enabled by defining VIDEO_TIMING_TEST_PATTERN_EN.
module video_timing_gen #(
  parameter int   H_ACTIVE   = 1280,
  parameter int   H_FP       = 110,
  parameter int   H_SYNC     = 40,
  parameter int   H_BP       = 220,
  parameter int   V_ACTIVE   = 720,
  parameter int   V_FP       = 5,
  parameter int   V_SYNC     = 5,
  parameter int   V_BP       = 20,
  parameter logic H_SYNC_POL = 1'b1,
  parameter logic V_SYNC_POL = 1'b1,
  parameter int   PIPE_LAT   = 2
) (
  input  logic        hdmi_clk,
  input  logic        reset,
  output logic [11:0] o_x,
  output logic [10:0] o_y,
  output logic        o_active,
  output logic        o_line_start,
  output logic        o_frame_start,
  input  logic [23:0] i_rgb,
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  input  logic        i_test_pattern,
`endif
  output logic [2:0]  hve_sync,
  output logic [23:0] rgb
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  function automatic logic hs_level(input logic [11:0] h);
    return (int'(h) >= HS_START && int'(h) < HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
  endfunction

  function automatic logic vs_level(input logic [10:0] v);
    return (int'(v) >= VS_START && int'(v) < VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
  endfunction

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  // {blue, green, red}: red on bars 0,1,4,5; green on 0-3; blue on even bars
  function automatic logic [23:0] bar_color(input logic [11:0] h);
    int       k;
    logic [2:0] kb;
    k = int'(h) / BAR_W;
    if (k > 7) k = 7;
    kb = 3'(k);
    return {{8{~kb[0]}}, {8{~kb[2]}}, {8{~kb[1]}}};
  endfunction
`endif

  logic        run;
  logic        h_wrap, v_wrap;
  logic [11:0] h_nxt;
  logic [10:0] v_nxt;
  logic        hs_req, vs_req;

  assign h_wrap = (o_x == H_LAST);
  assign v_wrap = (o_y == V_LAST);

  // The first edge after reset presents pixel (0,0) rather than advancing past it.
  always_comb begin
    h_nxt = '0;
    v_nxt = '0;
    if (run) begin
      h_nxt = h_wrap ? 12'd0 : o_x + 12'd1;
      v_nxt = h_wrap ? (v_wrap ? 11'd0 : o_y + 11'd1) : o_y;
    end
  end

  // Request stage: raster counters and request-aligned sync levels
  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      run           <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_active      <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      hs_req        <= ~H_SYNC_POL;
      vs_req        <= ~V_SYNC_POL;
    end else begin
      run           <= 1'b1;
      o_x           <= h_nxt;
      o_y           <= v_nxt;
      o_active      <= (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
      o_line_start  <= (h_nxt == 12'd0);
      o_frame_start <= (h_nxt == 12'd0) && (v_nxt == 11'd0);
      hs_req        <= hs_level(h_nxt);
      vs_req        <= vs_level(v_nxt);
    end
  end

  logic de_p [PIPE_LAT];
  logic hs_p [PIPE_LAT];
  logic vs_p [PIPE_LAT];

  // Delay stages p0..p(PIPE_LAT-1): match the pixel source latency
  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        de_p[i] <= 1'b0;
        hs_p[i] <= ~H_SYNC_POL;
        vs_p[i] <= ~V_SYNC_POL;
      end
    end else begin
      de_p[0] <= o_active;
      hs_p[0] <= hs_req;
      vs_p[0] <= vs_req;
      for (int i = 1; i < PIPE_LAT; i++) begin
        de_p[i] <= de_p[i-1];
        hs_p[i] <= hs_p[i-1];
        vs_p[i] <= vs_p[i-1];
      end
    end
  end

  logic [23:0] rgb_src;

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  logic [23:0] pat_req;
  logic [23:0] pat_p [PIPE_LAT];

  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      pat_req <= '0;
      for (int i = 0; i < PIPE_LAT; i++) pat_p[i] <= '0;
    end else begin
      pat_req  <= bar_color(h_nxt);
      pat_p[0] <= pat_req;
      for (int i = 1; i < PIPE_LAT; i++) pat_p[i] <= pat_p[i-1];
    end
  end

  assign rgb_src = i_test_pattern ? pat_p[PIPE_LAT-1] : i_rgb;
`else
  assign rgb_src = i_rgb;
`endif

  // Output stage: aligned syncs and masked pixel to hdmi
  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      hve_sync <= {1'b0, ~V_SYNC_POL, ~H_SYNC_POL};
      rgb      <= '0;
    end else begin
      hve_sync <= {de_p[PIPE_LAT-1], vs_p[PIPE_LAT-1], hs_p[PIPE_LAT-1]};
      rgb      <= de_p[PIPE_LAT-1] ? rgb_src : 24'h0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized self-checking bench for video_timing_gen on a small 14x7 raster,
// with positive- and negative-polarity instances side by side.
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int LAT = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] i_rgb;
  logic        tp;

  logic [11:0] ox0, ox1;
  logic [10:0] oy0, oy1;
  logic        act0, act1, ls0, ls1, fs0, fs1;
  logic [2:0]  hve0, hve1;
  logic [23:0] rgb0, rgb1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [23:0] src [0:4095];

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIPE_LAT(LAT)
  ) dut_pos (
    .hdmi_clk(clk), .reset(reset),
    .o_x(ox0), .o_y(oy0), .o_active(act0),
    .o_line_start(ls0), .o_frame_start(fs0),
    .i_rgb(i_rgb),
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    .i_test_pattern(tp),
`endif
    .hve_sync(hve0), .rgb(rgb0)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIPE_LAT(LAT)
  ) dut_neg (
    .hdmi_clk(clk), .reset(reset),
    .o_x(ox1), .o_y(oy1), .o_active(act1),
    .o_line_start(ls1), .o_frame_start(fs1),
    .i_rgb(i_rgb),
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    .i_test_pattern(tp),
`endif
    .hve_sync(hve1), .rgb(rgb1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference: cyc counts edges since reset release; edge c shows pixel c-1,
  // and the aligned hdmi side shows the pixel requested LAT+1 edges earlier.
  task automatic check_all();
    int h, v, q, hq, vq;
    logic de, hs_on, vs_on, act;
    logic [2:0] e_pos, e_neg;
    logic [23:0] e_rgb;
    h = 0; v = 0;
    if (cyc >= 1) begin
      h = (cyc - 1) % HT;
      v = ((cyc - 1) / HT) % VT;
    end
    act = (cyc >= 1) && (h < HA) && (v < VA);
    check("o_x",           32'(ox0), 32'(h));
    check("o_y",           32'(oy0), 32'(v));
    check("o_active",      32'(act0), 32'(act));
    check("o_line_start",  32'(ls0), 32'((cyc >= 1) && (h == 0)));
    check("o_frame_start", 32'(fs0), 32'((cyc >= 1) && (h == 0) && (v == 0)));
    check("o_x_neg",       32'(ox1), 32'(h));
    check("o_frame_neg",   32'(fs1), 32'((cyc >= 1) && (h == 0) && (v == 0)));
    if (cyc >= LAT + 2) begin
      q  = cyc - (LAT + 2);
      hq = q % HT;
      vq = (q / HT) % VT;
      de    = (hq < HA) && (vq < VA);
      hs_on = (hq >= HA + HF) && (hq < HA + HF + HS);
      vs_on = (vq >= VA + VF) && (vq < VA + VF + VS);
      e_pos = {de, vs_on, hs_on};
      e_neg = {de, ~vs_on, ~hs_on};
      e_rgb = de ? src[cyc - (LAT + 1)] : 24'h0;
    end else begin
      e_pos = 3'b000;
      e_neg = 3'b011;
      e_rgb = 24'h0;
    end
    check("hve_sync_pos", 32'(hve0), 32'(e_pos));
    check("hve_sync_neg", 32'(hve1), 32'(e_neg));
    check("rgb_pos",      32'(rgb0), 32'(e_rgb));
    check("rgb_neg",      32'(rgb1), 32'(e_rgb));
  endtask

  // One running clock: source answers each request LAT cycles later with random data.
  task automatic step();
    @(posedge clk);
    cyc++;
    src[cyc] = 24'($urandom);
    #1;
    i_rgb = (cyc > LAT) ? src[cyc - LAT] : 24'($urandom);
    check_all();
  endtask

  task automatic hold_reset(input int n);
    #1;
    reset = 1'b1;
    cyc   = 0;
    #1;
    check_all();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      i_rgb = 24'($urandom);
      check_all();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    i_rgb = '0;
    tp    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all();
    end
    reset = 1'b0;

    // three full frames cover every h/v wrap including the frame wrap
    for (int i = 0; i < 3 * HT * VT; i++) step();

    // restart, then reset asynchronously at h=5, v=2 for 3 cycles
    hold_reset(2);
    while (!(cyc >= 1 && (cyc - 1) % HT == 5 && ((cyc - 1) / HT) % VT == 2)) step();
    hold_reset(3);
    for (int i = 0; i < HT * VT + 20; i++) step();

    // random run lengths and reset points
    for (int r = 0; r < 8; r++) begin
      int len;
      len = int'($urandom_range(5, 250));
      for (int i = 0; i < len; i++) step();
      hold_reset(int'($urandom_range(1, 4)));
    end
    for (int i = 0; i < 40; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
